timer_cfg_sched: RTL and testbench
==================================

# timer_cfg_sched

APB4 master that shares one `apb4_timer` register port among `N_REQ` software/hardware requesters. Each requester submits a complete timer reprogramming job: prescaler, compare value and final control word. The block arbitrates jobs round-robin and runs each job as a fixed four-write APB4 sequence. It reports per-job completion and error back to the winning requester. It sits between the requesters and the timer's APB4 slave port, in place of a general bus master.

## Interface
- `N_REQ`, 4: number of requesters (2..8).
- `AW`, 32: APB address width.
- `DW`, 32: APB data width; also the width of all job fields.
- `BASE_ADDR`, 32'h0: timer base address.
- `CTRL_OFS`, 'h00: CTRL register offset.
- `PSCR_OFS`, 'h04: PSCR register offset.
- `CMP_OFS`, 'h0C: CMP register offset.

Ports:
- `clk_i`  in  1  clock.
- `rst_n_i`  in  1  asynchronous active-low reset.
- `req_valid_i`  in  N_REQ  job request per requester.
- `req_ready_o`  out  N_REQ  one-hot acceptance pulse; the job is captured in that cycle.
- `req_psc_i`  in  N_REQ×DW  prescaler value per requester.
- `req_cmp_i`  in  N_REQ×DW  compare value per requester.
- `req_ctrl_i`  in  N_REQ×DW  final CTRL word per requester.
- `done_o`  out  1  one-cycle job completion pulse.
- `done_id_o`  out  $clog2(N_REQ)  requester index for `done_o`.
- `done_err_o`  out  1  valid with `done_o`; 1 means the job was aborted on `pslverr`.
- `apb4`  `apb4_if.master`. The block drives `paddr`, `pprot`, `psel`, `penable`, `pwrite`, `pwdata` and `pstrb`, and samples `pready` and `pslverr`. `prdata` is unused.

## Operation
- **FSM states:** IDLE, SETUP, ACCESS, DONE.
- **Job sequence:** exactly 4 writes, in order:
  1. CTRL ← 0 (stop the timer)
  2. PSCR ← psc
  3. CMP ← cmp
  4. CTRL ← ctrl
- **Addresses:** `BASE_ADDR + ofs`.
- **Constant bus fields:** `pwrite`=1, `pstrb`=all ones, `pprot`=0 throughout.
- **IDLE:**
  - If any `req_valid_i` is set, the round-robin winner gets `req_ready_o[w]`=1 for one cycle.
  - That requester's psc/cmp/ctrl and its id are latched; step is set to 0; next state is SETUP.
- **Round robin:**
  - Search starts at `last_grant+1` and wraps modulo N_REQ.
  - `last_grant` resets to N_REQ-1, so requester 0 wins first.
  - `last_grant` updates only on acceptance.
  - Non-granted requesters see `req_ready_o`=0 and must hold `req_valid_i`.
- **SETUP:** `psel`=1, `penable`=0, address/data of the current step. Next state is ACCESS.
- **ACCESS:** `psel`=1, `penable`=1, address/data held stable.
  - Wait while `pready`=0.
  - `pready`=1 and `pslverr`=1: go to DONE with err=1. Remaining steps are not issued.
  - `pready`=1, `pslverr`=0, step<3: step+1, next state SETUP.
  - `pready`=1, `pslverr`=0, step=3: go to DONE with err=0.
- **DONE:** `done_o`=1 with `done_id_o`/`done_err_o`, `psel`=0, then IDLE.
- **Request inputs:** `req_valid_i` changes while a job is busy have no effect. Jobs are captured only in IDLE.
- **Reset (asynchronous, any state):**
  - FSM to IDLE; `last_grant` to N_REQ-1; step 0.
  - All outputs deasserted immediately.
  - The in-flight job is dropped; no `done_o` is produced for it.

## Timing
- **Reset values:**
  - `psel`, `penable`, `pwrite`, `done_o`, `done_err_o`, `req_ready_o`: 0.
  - `done_id_o`, `paddr`, `pwdata`: 0; `pstrb`: all ones; `pprot`: 0.
- **Zero-wait job** accepted at cycle T:
  - SETUP of write k at T+1+2k, ACCESS at T+2+2k.
  - `done_o` at T+9.
  - IDLE at T+10, when the next acceptance can occur.
- **Wait states:** each cycle with `pready`=0 adds one cycle to every later event.
- **Error on step k:** `done_o` the cycle after the erroring ACCESS.
- **Gaps:** no idle cycle between ACCESS of step k and SETUP of step k+1. `psel` stays 1 from the first SETUP to the last ACCESS.
- **Registered outputs:** all outputs are registered, except `req_ready_o`, which is combinational from IDLE and `req_valid_i`.

## Structure
- **Package `timer_cfg_pkg`:**
  - FSM state enum.
  - Step enum {STEP_STOP, STEP_PSCR, STEP_CMP, STEP_CTRL}.
  - `NUM_STEPS`=4.
- **Sub-module `timer_cfg_rr_arb`:**
  - Parameter N_REQ; inputs req, en, `last_grant`.
  - Outputs a one-hot grant and its index; purely combinational.
  - The `last_grant` register stays in the top module.
- **Top module:** FSM, job latch, step counter and APB drive.

## Test plan
- **Single job, zero wait:** req0 with psc=0x9, cmp=0x64, ctrl=0x3 → four writes: 0x00←0, 0x04←0x9, 0x0C←0x64, 0x00←0x3. `done_o` at T+9 with id=0, err=0.
- **Wait states:** slave holds `pready`=0 for 3 cycles on the PSCR write → `paddr`/`pwdata` stable throughout, `done_o` at T+12.
- **Arbitration order:** req0, req2 and req3 asserted together and held → jobs complete in order 0, 2, 3. Then re-asserting req0 and req3 gives 0 before 3 (pointer at 3).
- **Slave error:** `pslverr`=1 on the CMP write → no final CTRL write issued, `done_err_o`=1, `done_id_o` correct, next job accepted normally.
- **Reset mid-job:** `rst_n_i` low during the ACCESS of step 2 → `psel`/`penable` low asynchronously, no `done_o`. After release, a held req1 starts a fresh job at step 0.
- **Handshake:** a requester whose `req_valid_i` is held through another requester's job sees `req_ready_o` only at its grant, and its fields are sampled only in that cycle.

Source files
------------

// File: rtl/timer_cfg_pkg.sv
// Shared types for the timer configuration scheduler.
//   state_e   : sequencer FSM states
//   step_e    : which of the four register writes of a job is in flight
//   NUM_STEPS : number of APB writes per job
package timer_cfg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        STEP_STOP = 2'd0,
        STEP_PSCR = 2'd1,
        STEP_CMP  = 2'd2,
        STEP_CTRL = 2'd3
    } step_e;

    localparam int NUM_STEPS = 4;

endpackage

// File: rtl/apb4_if.sv
// APB4 bus bundle between the scheduler (master) and the timer register port (slave).
//   paddr/pprot/psel/penable/pwrite/pwdata/pstrb : master -> slave
//   pready/prdata/pslverr                        : slave -> master
interface apb4_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic [AW-1:0]   paddr;
    logic [2:0]      pprot;
    logic            psel;
    logic            penable;
    logic            pwrite;
    logic [DW-1:0]   pwdata;
    logic [DW/8-1:0] pstrb;
    logic            pready;
    logic [DW-1:0]   prdata;
    logic            pslverr;

    modport master (
        output paddr, pprot, psel, penable, pwrite, pwdata, pstrb,
        input  pready, prdata, pslverr
    );

    modport slave (
        input  paddr, pprot, psel, penable, pwrite, pwdata, pstrb,
        output pready, prdata, pslverr
    );
endinterface

// File: rtl/timer_cfg_rr_arb.sv
// Combinational round-robin arbiter.
//   req        : request vector
//   en         : grants are only produced while en is high
//   last_grant : index of the previous winner; search starts one above it
//   gnt        : one-hot grant
//   gnt_idx    : index of the granted requester
module timer_cfg_rr_arb #(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]         req,
    input  logic                     en,
    input  logic [$clog2(N_REQ)-1:0] last_grant,
    output logic [N_REQ-1:0]         gnt,
    output logic [$clog2(N_REQ)-1:0] gnt_idx
);
    localparam int IW = $clog2(N_REQ);

    logic          found;
    logic [IW-1:0] cand;

    // The previous winner is visited last (i = N_REQ), so it only wins
    // again when nobody else is asking.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        cand    = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            cand = IW'((int'(last_grant) + i) % N_REQ);
            if (en && !found && req[cand]) begin
                found     = 1'b1;
                gnt[cand] = 1'b1;
                gnt_idx   = cand;
            end
        end
    end
endmodule

// File: rtl/timer_cfg_sched.sv
// Shares one timer APB4 register port among N_REQ requesters. Each accepted
// job is replayed as four writes: CTRL<-0, PSCR<-psc, CMP<-cmp, CTRL<-ctrl.
//   clk_i, rst_n_i           : clock, async active-low reset
//   req_valid_i/req_ready_o  : per-requester job handshake (ready is one-hot)
//   req_psc_i/cmp_i/ctrl_i   : per-requester job fields, sampled at ready
//   done_o/done_id_o/err_o   : one-cycle completion pulse with owner and abort flag
//   apb4                     : APB4 master port toward the timer
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | no job; arbitrate and capture a job on req_ready_o
// ST_SETUP  | APB setup phase of the current step
// ST_ACCESS | APB access phase; waits for pready
// ST_DONE   | done_o pulse for the finished or aborted job
module timer_cfg_sched
    import timer_cfg_pkg::*;
#(
    parameter int            N_REQ     = 4,
    parameter int            AW        = 32,
    parameter int            DW        = 32,
    parameter logic [AW-1:0] BASE_ADDR = '0,
    parameter logic [AW-1:0] CTRL_OFS  = 'h00,
    parameter logic [AW-1:0] PSCR_OFS  = 'h04,
    parameter logic [AW-1:0] CMP_OFS   = 'h0C
) (
    input  logic                         clk_i,
    input  logic                         rst_n_i,
    input  logic [N_REQ-1:0]             req_valid_i,
    output logic [N_REQ-1:0]             req_ready_o,
    input  logic [N_REQ-1:0][DW-1:0]     req_psc_i,
    input  logic [N_REQ-1:0][DW-1:0]     req_cmp_i,
    input  logic [N_REQ-1:0][DW-1:0]     req_ctrl_i,
    output logic                         done_o,
    output logic [$clog2(N_REQ)-1:0]     done_id_o,
    output logic                         done_err_o,
    apb4_if.master                       apb4
);
    localparam int IW = $clog2(N_REQ);

    state_e        state;
    step_e         step;
    step_e         step_nxt;
    logic [DW-1:0] job_psc;
    logic [DW-1:0] job_cmp;
    logic [DW-1:0] job_ctrl;
    logic [IW-1:0] job_id;
    logic [IW-1:0] last_grant;

    logic [N_REQ-1:0] gnt;
    logic [IW-1:0]    gnt_idx;

    logic [AW-1:0] paddr_q;
    logic [DW-1:0] pwdata_q;
    logic          psel_q;
    logic          penable_q;
    logic          pwrite_q;
    logic          last_step;
    logic          unused_prdata;

    function automatic logic [AW-1:0] step_addr(input step_e s);
        case (s)
            STEP_PSCR: return BASE_ADDR + PSCR_OFS;
            STEP_CMP:  return BASE_ADDR + CMP_OFS;
            default:   return BASE_ADDR + CTRL_OFS;
        endcase
    endfunction

    function automatic logic [DW-1:0] step_data(input step_e s, input logic [DW-1:0] psc,
                                                input logic [DW-1:0] cmp, input logic [DW-1:0] ctrl);
        case (s)
            STEP_STOP: return '0;
            STEP_PSCR: return psc;
            STEP_CMP:  return cmp;
            default:   return ctrl;
        endcase
    endfunction

    timer_cfg_rr_arb #(.N_REQ(N_REQ)) u_arb (
        .req        (req_valid_i),
        .en         (state == ST_IDLE),
        .last_grant (last_grant),
        .gnt        (gnt),
        .gnt_idx    (gnt_idx)
    );

    assign req_ready_o = gnt;
    assign step_nxt    = step_e'(step + 2'd1);
    assign last_step   = (int'(step) == NUM_STEPS - 1);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state      <= ST_IDLE;
            step       <= STEP_STOP;
            last_grant <= IW'(N_REQ - 1);
            job_psc    <= '0;
            job_cmp    <= '0;
            job_ctrl   <= '0;
            job_id     <= '0;
            paddr_q    <= '0;
            pwdata_q   <= '0;
            psel_q     <= 1'b0;
            penable_q  <= 1'b0;
            pwrite_q   <= 1'b0;
            done_o     <= 1'b0;
            done_err_o <= 1'b0;
            done_id_o  <= '0;
        end else begin
            done_o     <= 1'b0;
            done_err_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (|gnt) begin
                        job_psc    <= req_psc_i[gnt_idx];
                        job_cmp    <= req_cmp_i[gnt_idx];
                        job_ctrl   <= req_ctrl_i[gnt_idx];
                        job_id     <= gnt_idx;
                        last_grant <= gnt_idx;
                        step       <= STEP_STOP;
                        paddr_q    <= step_addr(STEP_STOP);
                        pwdata_q   <= '0;
                        psel_q     <= 1'b1;
                        penable_q  <= 1'b0;
                        pwrite_q   <= 1'b1;
                        state      <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    penable_q <= 1'b1;
                    state     <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    if (apb4.pready) begin
                        if (apb4.pslverr || last_step) begin
                            // An error abandons the remaining writes of the job.
                            psel_q     <= 1'b0;
                            penable_q  <= 1'b0;
                            pwrite_q   <= 1'b0;
                            done_o     <= 1'b1;
                            done_err_o <= apb4.pslverr;
                            done_id_o  <= job_id;
                            state      <= ST_DONE;
                        end else begin
                            step      <= step_nxt;
                            paddr_q   <= step_addr(step_nxt);
                            pwdata_q  <= step_data(step_nxt, job_psc, job_cmp, job_ctrl);
                            penable_q <= 1'b0;
                            state     <= ST_SETUP;
                        end
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign apb4.paddr   = paddr_q;
    assign apb4.pwdata  = pwdata_q;
    assign apb4.psel    = psel_q;
    assign apb4.penable = penable_q;
    assign apb4.pwrite  = pwrite_q;
    assign apb4.pstrb   = '1;
    assign apb4.pprot   = '0;

    assign unused_prdata = ^apb4.prdata;
endmodule

// File: tb/tb_timer_cfg_sched.sv
module tb_timer_cfg_sched;
    localparam int N = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0]         req_valid;
    logic [N-1:0][31:0]   req_psc, req_cmp, req_ctrl;
    logic [N-1:0]         req_ready;
    logic                 done, done_err;
    logic [1:0]           done_id;

    apb4_if #(.AW(32), .DW(32)) bus ();

    timer_cfg_sched #(.N_REQ(N), .AW(32), .DW(32)) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_psc_i   (req_psc),
        .req_cmp_i   (req_cmp),
        .req_ctrl_i  (req_ctrl),
        .done_o      (done),
        .done_id_o   (done_id),
        .done_err_o  (done_err),
        .apb4        (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- model state ----------------
    int cyc = 0;
    always @(posedge clk) cyc++;

    int m_last = N - 1;
    int m_acc = -1;
    int exp_done_cyc = -1;
    int busy_until = -1;
    int exp_done_id, exp_done_err;
    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_data_q[$];

    // slave behaviour, configured by the stimulus and latched per job
    int wait_step = -1, wait_n = 0, err_step = -1;
    int j_wait_step = -1, j_wait_n = 0, j_err_step = -1;
    int job_wr = 0, acc_cnt = 0;
    logic prev_open = 1'b0;
    logic [31:0] prev_addr, prev_data;

    // observation logs for literal checks
    int log_acc[$], log_done[$], log_id[$], log_err[$], log_wr[$];
    logic [31:0] wr_addr_log[$], wr_data_log[$];

    logic [N-1:0] drop_req = '0;

    function automatic int rr_pick(input logic [N-1:0] v, input int last);
        for (int i = 1; i <= N; i++) begin
            if (v[(last + i) % N]) return (last + i) % N;
        end
        return -1;
    endfunction

    // compare + slave process, runs on the falling edge
    int           w, last_k, waits;
    logic [N-1:0] exp_rdy;
    logic         pr;
    logic [31:0]  ea, ed;
    always @(negedge clk) begin
        if (!rst_n) begin
            m_last = N - 1; m_acc = -1; exp_done_cyc = -1; busy_until = -1;
            exp_addr_q.delete(); exp_data_q.delete();
            job_wr = 0; acc_cnt = 0; prev_open = 1'b0;
            bus.pready = 1'b0; bus.pslverr = 1'b0;
        end else begin
            exp_rdy = '0;
            w = -1;
            if (cyc > busy_until && req_valid != '0) begin
                w = rr_pick(req_valid, m_last);
                exp_rdy[w] = 1'b1;
            end
            chk("req_ready", 32'(req_ready), 32'(exp_rdy));
            chk("done_o", 32'(done), 32'(cyc == exp_done_cyc));
            if (cyc == exp_done_cyc) begin
                chk("done_id", 32'(done_id), exp_done_id);
                chk("done_err", 32'(done_err), exp_done_err);
                log_done.push_back(cyc); log_id.push_back(int'(done_id));
                log_err.push_back(int'(done_err)); log_wr.push_back(job_wr);
                chk("writes_left", exp_addr_q.size(), 0);
            end
            chk("psel", 32'(bus.psel), 32'(cyc > m_acc && cyc < exp_done_cyc));
            if (bus.psel) begin
                chk("pwrite", 32'(bus.pwrite), 1);
                chk("pstrb", 32'(bus.pstrb), 32'hF);
                chk("pprot", 32'(bus.pprot), 0);
            end

            if (bus.psel && bus.penable) begin
                if (prev_open) begin
                    chk("paddr_stable", bus.paddr, prev_addr);
                    chk("pwdata_stable", bus.pwdata, prev_data);
                end
                pr = (job_wr == j_wait_step) ? (acc_cnt >= j_wait_n) : 1'b1;
                bus.pready  = pr;
                bus.pslverr = pr && (job_wr == j_err_step);
                if (pr) begin
                    if (exp_addr_q.size() == 0) begin
                        chk("unexpected_write", bus.paddr, 32'hFFFF_FFFF);
                    end else begin
                        ea = exp_addr_q.pop_front();
                        ed = exp_data_q.pop_front();
                        chk("write_addr", bus.paddr, ea);
                        chk("write_data", bus.pwdata, ed);
                    end
                    wr_addr_log.push_back(bus.paddr);
                    wr_data_log.push_back(bus.pwdata);
                    job_wr++;
                    acc_cnt = 0;
                    prev_open = 1'b0;
                end else begin
                    acc_cnt++;
                    prev_open = 1'b1;
                end
            end else begin
                bus.pready = 1'b0;
                bus.pslverr = 1'b0;
                prev_open = bus.psel;
            end
            prev_addr = bus.paddr;
            prev_data = bus.pwdata;

            if (w >= 0) begin
                m_last = w;
                m_acc = cyc;
                j_wait_step = wait_step; j_wait_n = wait_n; j_err_step = err_step;
                last_k = (err_step >= 0) ? err_step : 3;
                waits = (wait_step >= 0 && wait_step <= last_k) ? wait_n : 0;
                exp_done_cyc = cyc + 3 + 2 * last_k + waits;
                busy_until = exp_done_cyc;
                exp_done_id = w;
                exp_done_err = (err_step >= 0) ? 1 : 0;
                for (int k = 0; k <= last_k; k++) begin
                    case (k)
                        0: begin exp_addr_q.push_back(32'h0); exp_data_q.push_back(32'h0); end
                        1: begin exp_addr_q.push_back(32'h4); exp_data_q.push_back(req_psc[w]); end
                        2: begin exp_addr_q.push_back(32'hC); exp_data_q.push_back(req_cmp[w]); end
                        default: begin exp_addr_q.push_back(32'h0); exp_data_q.push_back(req_ctrl[w]); end
                    endcase
                end
                job_wr = 0; acc_cnt = 0;
                log_acc.push_back(cyc);
                drop_req[w] = 1'b1;
            end
        end
    end

    // A granted requester drops its request and scrambles its fields after capture.
    always @(posedge clk) begin
        #2;
        for (int i = 0; i < N; i++) begin
            if (drop_req[i]) begin
                req_valid[i] = 1'b0;
                req_psc[i]   = 32'hDEAD_0000 | i;
                req_cmp[i]   = 32'hBEEF_0000 | i;
                req_ctrl[i]  = 32'hCAFE_0000 | i;
            end
        end
        drop_req = '0;
    end

    task automatic clear_logs();
        log_acc.delete(); log_done.delete(); log_id.delete(); log_err.delete(); log_wr.delete();
        wr_addr_log.delete(); wr_data_log.delete();
    endtask

    task automatic set_job(input int i, input logic [31:0] p, input logic [31:0] c, input logic [31:0] t);
        req_psc[i] = p; req_cmp[i] = c; req_ctrl[i] = t;
        req_valid[i] = 1'b1;
    endtask

    task automatic wait_quiet();
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #3;
            if (req_valid == '0 && cyc > busy_until + 1) begin
                ok = 1'b1;
                break;
            end
        end
        chk("quiet_timeout", 32'(ok), 1);
    endtask

    initial begin
        logic ok;
        req_valid = '0; req_psc = '0; req_cmp = '0; req_ctrl = '0;
        bus.pready = 1'b0; bus.pslverr = 1'b0; bus.prdata = '0;
        #1;
        chk("rst_psel", 32'(bus.psel), 0);
        chk("rst_penable", 32'(bus.penable), 0);
        chk("rst_pwrite", 32'(bus.pwrite), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_done_err", 32'(done_err), 0);
        chk("rst_done_id", 32'(done_id), 0);
        chk("rst_ready", 32'(req_ready), 0);
        chk("rst_paddr", bus.paddr, 0);
        chk("rst_pwdata", bus.pwdata, 0);
        chk("rst_pstrb", 32'(bus.pstrb), 32'hF);
        chk("rst_pprot", 32'(bus.pprot), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // arbitration: 0, 2, 3 together from a fresh pointer
        @(posedge clk); #1;
        clear_logs();
        set_job(0, 32'h10, 32'h20, 32'h1);
        set_job(2, 32'h12, 32'h22, 32'h5);
        set_job(3, 32'h13, 32'h23, 32'h7);
        wait_quiet();
        chk("arb_count", log_id.size(), 3);
        if (log_id.size() == 3) begin
            chk("arb_first", log_id[0], 0);
            chk("arb_second", log_id[1], 2);
            chk("arb_third", log_id[2], 3);
            chk("arb_back_to_back", log_acc[1], log_done[0] + 1);
        end
        clear_logs();
        set_job(0, 32'h30, 32'h40, 32'h1);
        set_job(3, 32'h33, 32'h43, 32'h3);
        wait_quiet();
        chk("arb2_count", log_id.size(), 2);
        if (log_id.size() == 2) begin
            chk("arb2_first", log_id[0], 0);
            chk("arb2_second", log_id[1], 3);
        end

        // single zero-wait job
        @(posedge clk); #1;
        clear_logs();
        set_job(0, 32'h9, 32'h64, 32'h3);
        wait_quiet();
        if (log_done.size() == 1 && wr_addr_log.size() == 4) begin
            chk("single_latency", log_done[0] - log_acc[0], 9);
            chk("single_id", log_id[0], 0);
            chk("single_err", log_err[0], 0);
            chk("single_a0", wr_addr_log[0], 32'h0);  chk("single_d0", wr_data_log[0], 32'h0);
            chk("single_a1", wr_addr_log[1], 32'h4);  chk("single_d1", wr_data_log[1], 32'h9);
            chk("single_a2", wr_addr_log[2], 32'hC);  chk("single_d2", wr_data_log[2], 32'h64);
            chk("single_a3", wr_addr_log[3], 32'h0);  chk("single_d3", wr_data_log[3], 32'h3);
        end else begin
            chk("single_shape", log_done.size() * 16 + wr_addr_log.size(), 16 + 4);
        end

        // three wait states on the PSCR write
        @(posedge clk); #1;
        clear_logs();
        wait_step = 1; wait_n = 3;
        set_job(1, 32'h11, 32'h22, 32'h5);
        wait_quiet();
        wait_step = -1; wait_n = 0;
        chk("wait_count", log_done.size(), 1);
        if (log_done.size() == 1) begin
            chk("wait_latency", log_done[0] - log_acc[0], 12);
            chk("wait_id", log_id[0], 1);
        end

        // slave error on the CMP write of req2, req3 queued behind it
        @(posedge clk); #1;
        clear_logs();
        err_step = 2;
        set_job(2, 32'h52, 32'h62, 32'h9);
        set_job(3, 32'h53, 32'h63, 32'hB);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #3;
            if (log_acc.size() >= 1) begin ok = 1'b1; break; end
        end
        chk("err_accept_timeout", 32'(ok), 1);
        err_step = -1;
        wait_quiet();
        chk("err_count", log_id.size(), 2);
        if (log_id.size() == 2) begin
            chk("err_id", log_id[0], 2);
            chk("err_flag", log_err[0], 1);
            chk("err_writes", log_wr[0], 3);
            chk("err_latency", log_done[0] - log_acc[0], 7);
            chk("next_id", log_id[1], 3);
            chk("next_flag", log_err[1], 0);
            chk("next_writes", log_wr[1], 4);
        end

        // reset during the CMP access of req0's job, req1 held
        @(posedge clk); #1;
        clear_logs();
        set_job(0, 32'h70, 32'h71, 32'h72);
        set_job(1, 32'h80, 32'h81, 32'h82);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.psel && bus.penable && bus.paddr == 32'hC) begin ok = 1'b1; break; end
        end
        chk("rst_mid_reach", 32'(ok), 1);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_mid_psel", 32'(bus.psel), 0);
        chk("rst_mid_penable", 32'(bus.penable), 0);
        chk("rst_mid_done", 32'(done), 0);
        @(negedge clk);
        @(negedge clk);
        @(posedge clk); #1 rst_n = 1'b1;
        clear_logs();
        wait_quiet();
        chk("rst_job_count", log_id.size(), 1);
        if (log_id.size() == 1 && wr_addr_log.size() == 4) begin
            chk("rst_job_id", log_id[0], 1);
            chk("rst_job_a0", wr_addr_log[0], 32'h0);
            chk("rst_job_d1", wr_data_log[1], 32'h80);
            chk("rst_job_d3", wr_data_log[3], 32'h82);
        end

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
